// File: rtl/imm_encoder.sv
// imm_encoder: turns a 16-bit constant into the smallest immediate field
// (value, ZEXT, IMM_BITS) that the decode-stage extender expands back to the
// same constant. A constant that fits no field becomes an LBI/SLBI beat pair.
// Input and output use valid/ready handshakes, with a one-entry registered output.
module imm_encoder #(
    parameter bit EN_ZEXT  = 1'b1,  // allow zero-extended single-beat encodings
    parameter bit EN_IMM11 = 1'b1   // allow the 11-bit field
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [10:0] out_imm,
    output logic        out_zext,
    output logic [1:0]  out_imm_bits,
    output logic        out_last,
    output logic        out_split,
    output logic [7:0]  split_cnt
);

    // IDLE: output empty. ONE: single-beat result on the output.
    // HI: LBI beat on the output, SLBI pending. LO: SLBI beat on the output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ONE  = 2'b01,
        HI   = 2'b10,
        LO   = 2'b11
    } state_t;

    localparam logic [1:0] BITS_5  = 2'b00;
    localparam logic [1:0] BITS_8  = 2'b01;
    localparam logic [1:0] BITS_11 = 2'b10;

    state_t      state;
    state_t      state_next;
    logic        in_fire;
    logic        out_fire;
    logic        load_enc;
    logic        load_lo;
    logic [7:0]  lo_byte;

    // Result of the format search for the value currently on in_value.
    logic        fit_s5, fit_z5, fit_s8, fit_z8, fit_s11, fit_z11;
    logic        enc_fit;
    logic [10:0] enc_imm;
    logic        enc_zext;
    logic [1:0]  enc_bits;

    assign out_fire = out_valid & out_ready;
    // A new constant may enter when the output is empty, or when the last beat
    // of the current constant leaves in this same cycle (full throughput).
    assign in_ready = (state == IDLE) | (out_fire & out_last);
    assign in_fire  = in_valid & in_ready;
    assign out_valid = (state != IDLE);

    // A sign-extended N-bit field holds the value when bits [15:N-1] are all
    // copies of the sign; a zero-extended one when bits [15:N] are all zero.
    assign fit_s5  = (&in_value[15:4])  | ~(|in_value[15:4]);
    assign fit_z5  = ~(|in_value[15:5]);
    assign fit_s8  = (&in_value[15:7])  | ~(|in_value[15:7]);
    assign fit_z8  = ~(|in_value[15:8]);
    assign fit_s11 = (&in_value[15:10]) | ~(|in_value[15:10]);
    assign fit_z11 = ~(|in_value[15:11]);

    // Format search: first fit wins, smallest field first, sext before zext.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        enc_fit  = 1'b0;
        enc_imm  = 11'd0;
        enc_zext = 1'b0;
        enc_bits = BITS_5;
        if (fit_s5) begin
            enc_fit = 1'b1;
            enc_imm = {6'd0, in_value[4:0]};
        end else if (EN_ZEXT && fit_z5) begin
            enc_fit  = 1'b1;
            enc_imm  = {6'd0, in_value[4:0]};
            enc_zext = 1'b1;
        end else if (fit_s8) begin
            enc_fit  = 1'b1;
            enc_imm  = {3'd0, in_value[7:0]};
            enc_bits = BITS_8;
        end else if (EN_ZEXT && fit_z8) begin
            enc_fit  = 1'b1;
            enc_imm  = {3'd0, in_value[7:0]};
            enc_zext = 1'b1;
            enc_bits = BITS_8;
        end else if (EN_IMM11 && fit_s11) begin
            enc_fit  = 1'b1;
            enc_imm  = in_value[10:0];
            enc_bits = BITS_11;
        end else if (EN_IMM11 && EN_ZEXT && fit_z11) begin
            enc_fit  = 1'b1;
            enc_imm  = in_value[10:0];
            enc_zext = 1'b1;
            enc_bits = BITS_11;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples the pre-edge values of its neighbours.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and load strobes for the output register.
    always_comb begin
        state_next = state;
        load_enc   = 1'b0;
        load_lo    = 1'b0;
        case (state)
            IDLE: begin
                if (in_fire) begin
                    load_enc   = 1'b1;
                    state_next = enc_fit ? ONE : HI;
                end
            end
            ONE, LO: begin
                if (out_fire) begin
                    if (in_fire) begin
                        load_enc   = 1'b1;
                        state_next = enc_fit ? ONE : HI;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HI: begin
                if (out_fire) begin
                    load_lo    = 1'b1;
                    state_next = LO;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register: loads a new encoding or the pending SLBI beat, and
    // otherwise holds so the beat stays stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_imm      <= 11'd0;
            out_zext     <= 1'b0;
            out_imm_bits <= BITS_5;
            out_last     <= 1'b0;
            out_split    <= 1'b0;
            lo_byte      <= 8'd0;
        end else if (load_enc) begin
            if (enc_fit) begin
                out_imm      <= enc_imm;
                out_zext     <= enc_zext;
                out_imm_bits <= enc_bits;
                out_last     <= 1'b1;
                out_split    <= 1'b0;
            end else begin
                // LBI carries the sign-extended high byte; the low byte waits
                // for the SLBI beat, whose zero extension is implied by opcode.
                out_imm      <= {3'd0, in_value[15:8]};
                out_zext     <= 1'b0;
                out_imm_bits <= BITS_8;
                out_last     <= 1'b0;
                out_split    <= 1'b1;
                lo_byte      <= in_value[7:0];
            end
        end else if (load_lo) begin
            out_imm      <= {3'd0, lo_byte};
            out_zext     <= 1'b1;
            out_imm_bits <= BITS_8;
            out_last     <= 1'b1;
            out_split    <= 1'b1;
        end
    end

    // Saturating count of accepted constants that needed the split path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_cnt <= 8'd0;
        end else if (in_fire && !enc_fit && (split_cnt != 8'hFF)) begin
            split_cnt <= split_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: three instances (default, no zext,
// no 11-bit field) driven from a directed vector table, plus hand-written
// sequences for output stall, back-to-back throughput and reset mid-split.
module tb_imm_encoder;

    localparam int N_DUT = 3;

    logic        clk;
    logic        rst;
    logic        in_valid     [N_DUT];
    logic        in_ready     [N_DUT];
    logic [15:0] in_value     [N_DUT];
    logic        out_valid    [N_DUT];
    logic        out_ready    [N_DUT];
    logic [10:0] out_imm      [N_DUT];
    logic        out_zext     [N_DUT];
    logic [1:0]  out_imm_bits [N_DUT];
    logic        out_last     [N_DUT];
    logic        out_split    [N_DUT];
    logic [7:0]  split_cnt    [N_DUT];

    int n_checks;
    int n_errors;

    imm_encoder #(.EN_ZEXT(1'b1), .EN_IMM11(1'b1)) dut_full (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_value(in_value[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_imm(out_imm[0]),
        .out_zext(out_zext[0]), .out_imm_bits(out_imm_bits[0]), .out_last(out_last[0]),
        .out_split(out_split[0]), .split_cnt(split_cnt[0])
    );

    imm_encoder #(.EN_ZEXT(1'b0), .EN_IMM11(1'b1)) dut_nozext (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_value(in_value[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_imm(out_imm[1]),
        .out_zext(out_zext[1]), .out_imm_bits(out_imm_bits[1]), .out_last(out_last[1]),
        .out_split(out_split[1]), .split_cnt(split_cnt[1])
    );

    imm_encoder #(.EN_ZEXT(1'b1), .EN_IMM11(1'b0)) dut_no11 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_value(in_value[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_imm(out_imm[2]),
        .out_zext(out_zext[2]), .out_imm_bits(out_imm_bits[2]), .out_last(out_last[2]),
        .out_split(out_split[2]), .split_cnt(split_cnt[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          dut;
        logic [15:0] value;
        logic        split;
        logic [10:0] imm;     // single-beat field, or LBI byte when split
        logic [10:0] imm_lo;  // SLBI byte when split
        logic        zext;
        logic [1:0]  bits;
    } vec_t;

    localparam int N_VEC = 18;
    vec_t vecs [N_VEC];
    int   exp_cnt [N_DUT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one value, wait (bounded) for acceptance, drop valid after the edge.
    task automatic send(input int d, input logic [15:0] v);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_value[d] = v;
        while (!in_ready[d] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready[d]) check("accept_timeout", {31'd0, in_ready[d]}, 32'd1);
        @(posedge clk);
        #1;
        in_valid[d] = 1'b0;
    endtask

    task automatic check_beat(input int d, input string tag, input logic [10:0] imm,
                              input logic zext, input logic [1:0] bits,
                              input logic last, input logic split);
        check({tag, ".valid"}, {31'd0, out_valid[d]}, 32'd1);
        check({tag, ".imm"},   {21'd0, out_imm[d]},   {21'd0, imm});
        check({tag, ".zext"},  {31'd0, out_zext[d]},  {31'd0, zext});
        check({tag, ".bits"},  {30'd0, out_imm_bits[d]}, {30'd0, bits});
        check({tag, ".last"},  {31'd0, out_last[d]},  {31'd0, last});
        check({tag, ".split"}, {31'd0, out_split[d]}, {31'd0, split});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int d = 0; d < N_DUT; d++) begin
            in_valid[d]  = 1'b0;
            in_value[d]  = 16'h0000;
            out_ready[d] = 1'b1;
            exp_cnt[d]   = 0;
        end

        //          dut  value     split imm      imm_lo   zext  bits
        vecs[0]  = '{0, 16'h000F, 1'b0, 11'h00F, 11'h000, 1'b0, 2'b00};
        vecs[1]  = '{0, 16'hFFF0, 1'b0, 11'h010, 11'h000, 1'b0, 2'b00};
        vecs[2]  = '{0, 16'h001F, 1'b0, 11'h01F, 11'h000, 1'b1, 2'b00};
        vecs[3]  = '{0, 16'h0010, 1'b0, 11'h010, 11'h000, 1'b1, 2'b00};
        vecs[4]  = '{0, 16'h0080, 1'b0, 11'h080, 11'h000, 1'b1, 2'b01};
        vecs[5]  = '{0, 16'hFF80, 1'b0, 11'h080, 11'h000, 1'b0, 2'b01};
        vecs[6]  = '{0, 16'h0400, 1'b0, 11'h400, 11'h000, 1'b1, 2'b10};
        vecs[7]  = '{0, 16'h03FF, 1'b0, 11'h3FF, 11'h000, 1'b0, 2'b10};
        vecs[8]  = '{0, 16'hFC00, 1'b0, 11'h400, 11'h000, 1'b0, 2'b10};
        vecs[9]  = '{0, 16'h07FF, 1'b0, 11'h7FF, 11'h000, 1'b1, 2'b10};
        vecs[10] = '{0, 16'h1234, 1'b1, 11'h012, 11'h034, 1'b0, 2'b01};
        vecs[11] = '{0, 16'h8001, 1'b1, 11'h080, 11'h001, 1'b0, 2'b01};
        vecs[12] = '{0, 16'h0800, 1'b1, 11'h008, 11'h000, 1'b0, 2'b01};
        vecs[13] = '{1, 16'h001F, 1'b0, 11'h01F, 11'h000, 1'b0, 2'b01};
        vecs[14] = '{1, 16'h0080, 1'b0, 11'h080, 11'h000, 1'b0, 2'b10};
        vecs[15] = '{1, 16'hFFFF, 1'b0, 11'h01F, 11'h000, 1'b0, 2'b00};
        vecs[16] = '{2, 16'h0400, 1'b1, 11'h004, 11'h000, 1'b0, 2'b01};
        vecs[17] = '{2, 16'h03FF, 1'b1, 11'h003, 11'h0FF, 1'b0, 2'b01};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            check("reset.out_valid", {31'd0, out_valid[d]}, 32'd0);
            check("reset.out_imm",   {21'd0, out_imm[d]},   32'd0);
            check("reset.split_cnt", {24'd0, split_cnt[d]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < N_DUT; d++) begin
            check("reset.in_ready", {31'd0, in_ready[d]}, 32'd1);
        end

        // Directed table: first beat one cycle after accept, then the SLBI
        // beat for splits, then the output must be empty again.
        for (int i = 0; i < N_VEC; i++) begin
            int d;
            d = vecs[i].dut;
            send(d, vecs[i].value);
            if (vecs[i].split) begin
                exp_cnt[d]++;
                check_beat(d, $sformatf("v%0d.lbi", i), vecs[i].imm, 1'b0, 2'b01, 1'b0, 1'b1);
                @(posedge clk);
                #1;
                check_beat(d, $sformatf("v%0d.slbi", i), vecs[i].imm_lo, 1'b1, 2'b01, 1'b1, 1'b1);
            end else begin
                check_beat(d, $sformatf("v%0d", i), vecs[i].imm, vecs[i].zext, vecs[i].bits, 1'b1, 1'b0);
            end
            @(posedge clk);
            #1;
            check($sformatf("v%0d.drain", i), {31'd0, out_valid[d]}, 32'd0);
        end
        for (int d = 0; d < N_DUT; d++) begin
            check($sformatf("split_cnt%0d", d), {24'd0, split_cnt[d]}, exp_cnt[d]);
        end

        // Consumer stalls for 5 cycles on the LBI beat: everything holds.
        out_ready[0] = 1'b0;
        send(0, 16'h1234);
        for (int c = 0; c < 5; c++) begin
            check_beat(0, $sformatf("stall%0d", c), 11'h012, 1'b0, 2'b01, 1'b0, 1'b1);
            check($sformatf("stall%0d.in_ready", c), {31'd0, in_ready[0]}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        check_beat(0, "stall.slbi", 11'h034, 1'b1, 2'b01, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        check("stall.drain", {31'd0, out_valid[0]}, 32'd0);

        // Back-to-back constants: one beat per cycle with out_ready held high.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_value[0] = 16'h0001;
        @(posedge clk);
        #1;
        in_value[0] = 16'h0002;
        check_beat(0, "b2b0", 11'h001, 1'b0, 2'b00, 1'b1, 1'b0);
        check("b2b0.in_ready", {31'd0, in_ready[0]}, 32'd1);
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check_beat(0, "b2b1", 11'h002, 1'b0, 2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("b2b.drain", {31'd0, out_valid[0]}, 32'd0);

        // Reset while the LBI beat is held: output and counter clear at once,
        // and the pending SLBI beat never appears.
        out_ready[0] = 1'b0;
        send(0, 16'h1234);
        check("hi.split", {31'd0, out_split[0]}, 32'd1);
        check("hi.last",  {31'd0, out_last[0]},  32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("rst_hi.out_valid", {31'd0, out_valid[0]}, 32'd0);
        check("rst_hi.split_cnt", {24'd0, split_cnt[0]}, 32'd0);
        check("rst_hi.out_split", {31'd0, out_split[0]}, 32'd0);
        out_ready[0] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_hi.no_lo%0d", c), {31'd0, out_valid[0]}, 32'd0);
        end
        send(0, 16'h0003);
        check_beat(0, "post_rst", 11'h003, 1'b0, 2'b00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst.drain", {31'd0, out_valid[0]}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate-extension path. Accepts a 16-bit constant and produces the smallest immediate field, with its ZEXT and IMM_BITS controls, that the decode-stage extender expands back to the same value.
- A constant that fits no 5/8/11-bit field is emitted as a two-beat LBI/SLBI pair.
- Sits in the constant-loading / ROM-patch path that generates instruction words.
- Uses valid/ready handshakes on input and output, with a one-entry registered output.

Parameters:
- EN_ZEXT, 1, 1 permits zero-extended encodings; 0 restricts to sign-extended encodings only.
- EN_IMM11, 1, 1 permits the 11-bit field; 0 restricts to 5- and 8-bit fields.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  value is presented
- in_ready  output  1  block accepts value this cycle
- in_value  input  16  constant to encode
- out_valid  output  1  output beat is valid
- out_ready  input  1  consumer accepts the beat
- out_imm  output  11  immediate field; bits above the selected width are 0
- out_zext  output  1  1 = zero-extend, 0 = sign-extend
- out_imm_bits  output  2  00 = 5 bits, 01 = 8 bits, 10 = 11 bits; 11 is never driven
- out_last  output  1  final beat of this constant
- out_split  output  1  beat belongs to a two-beat LBI/SLBI pair
- split_cnt  output  8  saturating count of constants that needed a split

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high on rst.
- Reset values, all forced immediately on rst:
  - out_valid=0, out_imm=0, out_zext=0, out_imm_bits=00
  - out_last=0, out_split=0, split_cnt=0
  - state=IDLE
  - rst asserted mid-split drops the pending low beat; no beat is emitted after reset.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready = (state==IDLE) | (out_fire & out_last). Accepting back-to-back constants at full throughput is required.
  - in_ready depends combinationally on out_ready. Nothing else is combinational from input to output.
  - Outputs hold stable while out_valid & !out_ready.
- Latency: the first beat is valid on the cycle after in_fire.
- Format search, first fit wins, in this order:
  1. 5-bit sext: value in [-16, 15]
  2. 5-bit zext: value in [0, 31]
  3. 8-bit sext: value in [-128, 127]
  4. 8-bit zext: value in [0, 255]
  5. 11-bit sext: value in [-1024, 1023]
  6. 11-bit zext: value in [0, 2047]
  - zext candidates are skipped when EN_ZEXT=0.
  - 11-bit candidates are skipped when EN_IMM11=0.
- Single-beat result: out_imm = value[width-1:0], upper bits 0. out_last=1, out_split=0.
- Split path, taken when no candidate fits:
  - Beat 0 (LBI): out_imm[7:0]=value[15:8], out_zext=0, out_imm_bits=01, out_last=0, out_split=1.
  - Beat 1 (SLBI): out_imm[7:0]=value[7:0], out_zext=1, out_imm_bits=01, out_last=1, out_split=1.
  - The split path is always available, including when EN_ZEXT=0, because SLBI zero-extension is implicit to that opcode.
- State machine:
  - IDLE -> ONE on in_fire with a fit.
  - IDLE -> HI on in_fire without a fit.
  - ONE -> IDLE on out_fire with no new in_fire.
  - ONE -> ONE or HI on out_fire with a simultaneous in_fire, according to the new value.
  - HI -> LO on out_fire.
  - LO behaves as ONE.
- split_cnt increments on the in_fire that enters HI and saturates at 255.
- Round-trip invariants:
  - Single beat: extend(out_imm, out_zext, out_imm_bits) == value.
  - Split: (sext8(hi) << 8) | zext8(lo) == value.
- Boundary values:
  - 0x000F and 0xFFF0 are 5-bit sext.
  - 0x0010 is 5-bit zext.
  - 0x03FF and 0xFC00 are 11-bit sext.
  - 0x07FF is 11-bit zext.
  - 0x0800 splits.

Test Plan:
- in_value 0x000F, then 0xFFF0, then 0x001F -> imm 0x00F/zext 0/bits 00; imm 0x010/0/00; imm 0x01F/1/00. Each arrives one cycle after accept with last=1.
- 0x0080, 0xFF80, 0x0400 -> imm 0x080/1/01; imm 0x080/0/01; imm 0x400/1/10.
- 0x1234 -> beat 0: imm 0x012/0/01, last 0; beat 1: imm 0x034/1/01, last 1, split 1. Then 0x8001 -> beats 0x080 and 0x001. split_cnt=2.
- EN_ZEXT=0 with 0x001F -> imm 0x01F/0/01. EN_IMM11=0 with 0x0400 -> split 0x004, 0x000.
- Hold out_ready=0 for 5 cycles during a split -> outputs stable and in_ready=0. Then back-to-back 0x0001, 0x0002 with out_ready=1 -> one beat per cycle.
- Assert rst while in state HI -> out_valid=0 and split_cnt=0 immediately. No LO beat is emitted. The next 0x0003 encodes normally.
